// File: rtl/frame_pkg.sv
// Shared types and header layout for the frame packer.
package frame_pkg;

  localparam logic [15:0] SYNC_WORD    = 16'hEB90;
  localparam int          HDR_SYNC_LSB = 48;
  localparam int          HDR_CH_LSB   = 46;
  localparam int          HDR_SEQ_LSB  = 16;
  localparam int          HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TAIL = 2'd3
  } out_state_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] sum;
  } desc_t;

  function automatic logic [63:0] make_header(input logic [1:0]  ch,
                                              input logic [15:0] seq,
                                              input logic [15:0] len);
    logic [63:0] hdr;
    hdr                       = 64'd0;
    hdr[HDR_SYNC_LSB +: 16]   = SYNC_WORD;
    hdr[HDR_CH_LSB   +: 2]    = ch;
    hdr[HDR_SEQ_LSB  +: 16]   = seq;
    hdr[HDR_LEN_LSB  +: 16]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     rdclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   used
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current fill state.
  always_comb begin
    full      = (cnt_r == (AW+1)'(DEPTH));
    empty     = (cnt_r == {(AW+1){1'b0}});
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    used      = cnt_r;
    rd_data   = mem_r[rd_ptr_r];
  end

  // Storage array write port.
  always_ff @(posedge rdclk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/frame_packer.sv
// Buffers fixed-length input frames and replays them as header, payload and checksum tail;
// whole frames are dropped at frame start when buffer or descriptor space is short.
module frame_packer
  import frame_pkg::*;
#(
  parameter int FRAME_LEN  = 128,
  parameter int BUF_DEPTH  = 512,
  parameter int DESC_DEPTH = 4
) (
  input  logic        rdclk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_ch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] drop_cnt
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int BW = $clog2(BUF_DEPTH) + 1;
  localparam int DW = $clog2(DESC_DEPTH) + 1;

  logic [CW-1:0] in_cnt_r;
  logic          admit_r;
  logic [1:0]    ch_r;
  logic [63:0]   sum_r;
  logic          desc_pend_r;
  logic [15:0]   drop_cnt_r;

  logic          frame_start_s, last_word_s, admit_now_s, admit_s, pay_push_s;
  logic          buf_room_s, desc_room_s;
  logic [BW-1:0] buf_used_s;
  logic [DW-1:0] desc_used_s;
  logic [63:0]   pay_head_s;
  logic          pay_full_s, pay_empty_s, desc_full_s, desc_empty_s;
  desc_t         desc_wr_s, desc_head_s;

  out_state_t    state_r, state_nx_s;
  logic [CW-1:0] out_cnt_r;
  logic [15:0]   seq_r;
  logic          xfer_s, pay_load_s, desc_pop_s;
  logic          out_valid_r, out_sof_r, out_eof_r;
  logic [63:0]   out_data_r;
  logic          nx_valid_s, nx_sof_s, nx_eof_s;
  logic [63:0]   nx_data_s;

  // Admission decision; a descriptor still waiting to be pushed counts as occupying a slot.
  always_comb begin
    frame_start_s = (in_cnt_r == {CW{1'b0}});
    last_word_s   = (in_cnt_r == CW'(FRAME_LEN - 1));
    buf_room_s    = !pay_full_s && ((BW'(BUF_DEPTH) - buf_used_s) >= BW'(FRAME_LEN));
    desc_room_s   = !desc_full_s && ((desc_used_s + DW'(desc_pend_r)) < DW'(DESC_DEPTH));
    admit_now_s   = buf_room_s && desc_room_s;
    if (frame_start_s) admit_s = admit_now_s;
    else               admit_s = admit_r;
    pay_push_s    = in_valid && admit_s;
    desc_wr_s.ch  = ch_r;
    desc_wr_s.sum = sum_r;
  end

  // Input word counting, channel latch and running checksum.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_r    <= {CW{1'b0}};
      admit_r     <= 1'b0;
      ch_r        <= 2'd0;
      sum_r       <= 64'd0;
      desc_pend_r <= 1'b0;
    end else begin
      desc_pend_r <= in_valid && last_word_s && admit_s;
      if (in_valid) begin
        in_cnt_r <= in_cnt_r + CW'(1);
        if (frame_start_s) begin
          ch_r    <= in_ch;
          admit_r <= admit_now_s;
          sum_r   <= in_data;
        end else begin
          sum_r   <= sum_r + in_data;
        end
      end
    end
  end

  // Saturating count of frames refused at frame start.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 16'd0;
    end else if (in_valid && frame_start_s && !admit_now_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  sync_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_pay_fifo (
    .rdclk   (rdclk),
    .rst_n   (rst_n),
    .push    (pay_push_s),
    .wr_data (in_data),
    .pop     (pay_load_s),
    .rd_data (pay_head_s),
    .full    (pay_full_s),
    .empty   (pay_empty_s),
    .used    (buf_used_s)
  );

  sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .rdclk   (rdclk),
    .rst_n   (rst_n),
    .push    (desc_pend_r),
    .wr_data (desc_wr_s),
    .pop     (desc_pop_s),
    .rd_data (desc_head_s),
    .full    (desc_full_s),
    .empty   (desc_empty_s),
    .used    (desc_used_s)
  );

  // Output sequencing; a payload word is popped as it is loaded into the output register.
  always_comb begin
    xfer_s     = out_valid_r && out_ready;
    state_nx_s = state_r;
    pay_load_s = 1'b0;
    desc_pop_s = 1'b0;
    case (state_r)
      IDLE: if (!desc_empty_s && !pay_empty_s) state_nx_s = HDR;
            else                               state_nx_s = IDLE;
      HDR:  if (xfer_s) begin
              state_nx_s = PAY;
              pay_load_s = 1'b1;
            end else begin
              state_nx_s = HDR;
            end
      PAY:  if (xfer_s) begin
              if (out_cnt_r == CW'(FRAME_LEN - 1)) begin
                state_nx_s = TAIL;
              end else begin
                state_nx_s = PAY;
                pay_load_s = 1'b1;
              end
            end else begin
              state_nx_s = PAY;
            end
      TAIL: if (xfer_s) begin
              state_nx_s = IDLE;
              desc_pop_s = 1'b1;
            end else begin
              state_nx_s = TAIL;
            end
      default: state_nx_s = IDLE;
    endcase
  end

  // Next output word, chosen by the state being entered so outputs can be registered.
  always_comb begin
    nx_valid_s = 1'b1;
    nx_sof_s   = 1'b0;
    nx_eof_s   = 1'b0;
    nx_data_s  = out_data_r;
    case (state_nx_s)
      IDLE: begin
        nx_valid_s = 1'b0;
        nx_data_s  = 64'd0;
      end
      HDR: begin
        nx_sof_s  = 1'b1;
        nx_data_s = make_header(desc_head_s.ch, seq_r, 16'(FRAME_LEN));
      end
      PAY: if (pay_load_s) nx_data_s = pay_head_s;
           else            nx_data_s = out_data_r;
      TAIL: begin
        nx_eof_s  = 1'b1;
        nx_data_s = desc_head_s.sum;
      end
      default: begin
        nx_valid_s = 1'b0;
        nx_data_s  = 64'd0;
      end
    endcase
  end

  // State, counters and registered output stage.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_cnt_r   <= {CW{1'b0}};
      seq_r       <= 16'd0;
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      out_data_r  <= 64'd0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= nx_valid_s;
      out_sof_r   <= nx_sof_s;
      out_eof_r   <= nx_eof_s;
      out_data_r  <= nx_data_s;
      if ((state_r == PAY) && xfer_s) out_cnt_r <= out_cnt_r + CW'(1);
      if (desc_pop_s)                 seq_r     <= seq_r + 16'd1;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sof   = out_sof_r;
  assign out_eof   = out_eof_r;
  assign out_data  = out_data_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: expected output words are queued as frames are driven
// and compared as the packer transfers them.
module tb_frame_packer;

  localparam int FL = 128;

  logic        rdclk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] drop_cnt;

  frame_packer dut (
    .rdclk     (rdclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .drop_cnt  (drop_cnt)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  typedef struct {
    logic [63:0] data;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec;
  int          n_err;
  int          cyc;
  int          last_eof;
  bit          gap_chk;
  bit          rand_rdy;
  bit          stall_r;
  logic [63:0] held_data;
  logic [15:0] exp_seq;
  logic [15:0] exp_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (stall_r) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, held_data);
    end
    if (out_valid === 1'b1) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.data);
          chk("sof", 64'(out_sof), 64'(e.sof));
          chk("eof", 64'(out_eof), 64'(e.eof));
          if (out_sof && gap_chk && last_eof >= 0)
            chk("idle_gap", 64'(cyc - last_eof), 64'd2);
          if (out_eof) last_eof = cyc;
        end
      end
      stall_r   = !out_ready;
      held_data = out_data;
    end else begin
      stall_r = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge rdclk);
    if (rst_n) monitor();
    @(posedge rdclk);
    #1;
    cyc++;
    if (rand_rdy) out_ready = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [63:0] base,
                            input bit admit, input int gap_at);
    exp_t        e;
    logic [63:0] s;
    if (admit) begin
      s = 64'd0;
      e = '{data: {16'hEB90, ch, 14'd0, exp_seq, 16'd128}, sof: 1'b1, eof: 1'b0};
      exp_q.push_back(e);
      for (int i = 0; i < FL; i++) begin
        e = '{data: base + 64'(i), sof: 1'b0, eof: 1'b0};
        s = s + base + 64'(i);
        exp_q.push_back(e);
      end
      e = '{data: s, sof: 1'b0, eof: 1'b1};
      exp_q.push_back(e);
      exp_seq = exp_seq + 16'd1;
    end else begin
      exp_drop = exp_drop + 16'd1;
    end
    for (int i = 0; i < FL; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (3) tick();
      end
      in_valid = 1'b1;
      in_data  = base + 64'(i);
      in_ch    = (i == 0) ? ch : 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 6000 && exp_q.size() > 0; k++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; last_eof = -1;
    gap_chk = 1'b0; rand_rdy = 1'b0; stall_r = 1'b0; held_data = 64'd0;
    exp_seq = 16'd0; exp_drop = 16'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 64'd0; in_ch = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge rdclk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sof", 64'(out_sof), 64'd0);
    chk("rst_eof", 64'(out_eof), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // single frame, ch2, data 1..128, header latency
    out_ready = 1'b1;
    send_frame(2'd2, 64'd1, 1'b1, -1);
    tick();
    chk("lat_n1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_n2_valid", 64'(out_valid), 64'd1);
    chk("lat_n2_sof", 64'(out_sof), 64'd1);
    drain();

    // back-to-back frames with one idle cycle between them
    gap_chk = 1'b1; last_eof = -1;
    send_frame(2'd0, 64'h1000, 1'b1, -1);
    send_frame(2'd3, 64'h2000, 1'b1, -1);
    drain();
    gap_chk = 1'b0;

    // random 30% out_ready, input gaps, checksum wrap
    rand_rdy = 1'b1;
    send_frame(2'd1, 64'hA5A5_0000_0000_0000, 1'b1, 64);
    repeat (7) tick();
    send_frame(2'd2, 64'h0123_4567_89AB_CDEF, 1'b1, -1);
    send_frame(2'd3, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 10);
    drain();
    rand_rdy = 1'b0;

    // output stalled across five frames: fifth is dropped
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(2'(f), 64'(f) * 64'h1_0000, (f < 4), -1);
    tick();
    chk("drop_cnt_stall", 64'(drop_cnt), 64'(exp_drop));
    out_ready = 1'b1;
    drain();

    // sequence number wrap
    force dut.seq_r = 16'hFFFF;
    tick();
    release dut.seq_r;
    exp_seq = 16'hFFFF;
    send_frame(2'd1, 64'h5000, 1'b1, -1);
    send_frame(2'd2, 64'h6000, 1'b1, -1);
    drain();

    // reset in the middle of a frame
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h9000 + 64'(i);
      in_ch    = 2'd3;
      tick();
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sof", 64'(out_sof), 64'd0);
    chk("mid_rst_eof", 64'(out_eof), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    stall_r = 1'b0;
    exp_seq = 16'd0;
    exp_drop = 16'd0;
    send_frame(2'd1, 64'h7700, 1'b1, -1);
    drain();
    chk("final_drop", 64'(drop_cnt), 64'(exp_drop));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
